// File: rtl/window_frame_scheduler.sv
// window_frame_scheduler: buffers audio samples in an N-entry ring and replays overlapping N-sample frames (hop HOP) to hanning_window.
// Ports: clk, reset (async active-low), enable; in_sample/in_valid/in_ready from the source;
//   win_sample/win_valid/win_ready and win_frame_done toward hanning_window;
//   frame_start, busy, frame_count, seq_error status.
// Optional macro WIN_SCHED_OVERRUN_EN adds overrun_count (saturating) and sticky overrun.
module window_frame_scheduler #(
   parameter int W   = 16,
   parameter int N   = 1024,
   parameter int HOP = 512
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic [W-1:0] in_sample,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] win_sample,
   output logic         win_valid,
   input  logic         win_ready,
   input  logic         win_frame_done,
   output logic         frame_start,
   output logic         busy,
   output logic [15:0]  frame_count,
   output logic         seq_error
`ifdef WIN_SCHED_OVERRUN_EN
   ,
   output logic [15:0]  overrun_count,
   output logic         overrun
`endif
);
   localparam int AW = $clog2(N);
   localparam int CW = AW + 1;
   typedef enum logic [1:0] {FILL, STREAM, WAIT_DONE} state_t;
   state_t state, state_nx;
   logic [W-1:0]  mem [N];
   logic [AW-1:0] wr_ptr, base, rd_addr;
   logic [CW-1:0] new_cnt, rd_idx, iss_idx, target;
   logic          first_frame, wr_en, load;
   assign wr_en   = in_valid && in_ready;
   assign rd_addr = base + iss_idx[AW-1:0];
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= FILL;
      else        state <= state_nx;
   // in_ready is gated by reset so every output reads 0 while reset is held.
   // iss_idx runs one ahead of rd_idx: the output register is refilled on the
   // same cycle its current sample is accepted, giving one sample per cycle.
   always_comb begin
      state_nx    = state;
      in_ready    = 1'b0;
      frame_start = 1'b0;
      busy        = 1'b0;
      load        = 1'b0;
      case (state)
         FILL: begin
            in_ready    = reset && (new_cnt < target);
            frame_start = (new_cnt == target) && enable;
            state_nx    = frame_start ? STREAM : FILL;
         end
         STREAM: begin
            busy     = 1'b1;
            in_ready = reset && (new_cnt < rd_idx) && (new_cnt < CW'(HOP));
            load     = (iss_idx < CW'(N)) && (!win_valid || win_ready);
            state_nx = (win_valid && win_ready && rd_idx == CW'(N - 1)) ? WAIT_DONE : STREAM;
         end
         WAIT_DONE: begin
            busy     = 1'b1;
            in_ready = reset && (new_cnt < target);
            state_nx = win_frame_done ? FILL : WAIT_DONE;
         end
         default: state_nx = FILL;
      endcase
   end
   always_ff @(posedge clk)
      if (wr_en) mem[wr_ptr] <= in_sample;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         wr_ptr      <= '0;
         base        <= '0;
         new_cnt     <= '0;
         rd_idx      <= '0;
         iss_idx     <= '0;
         target      <= CW'(N);
         first_frame <= 1'b1;
         win_sample  <= '0;
         win_valid   <= 1'b0;
         frame_count <= '0;
         seq_error   <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (frame_start) new_cnt <= '0;
         else if (wr_en) new_cnt <= new_cnt + CW'(1);
         if (frame_start) begin
            base        <= first_frame ? '0 : base + AW'(HOP);
            first_frame <= 1'b0;
            rd_idx      <= '0;
            iss_idx     <= '0;
            target      <= CW'(HOP);
         end else if (win_valid && win_ready) rd_idx <= rd_idx + CW'(1);
         if (load) begin
            win_sample <= mem[rd_addr];
            win_valid  <= 1'b1;
            iss_idx    <= iss_idx + CW'(1);
         end else if (win_ready) win_valid <= 1'b0;
         if (state == WAIT_DONE && win_frame_done) frame_count <= frame_count + 16'd1;
         if (state != WAIT_DONE && win_frame_done) seq_error <= 1'b1;
      end
`ifdef WIN_SCHED_OVERRUN_EN
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         overrun_count <= '0;
         overrun       <= 1'b0;
      end else if (in_valid && !in_ready) begin
         overrun <= 1'b1;
         if (overrun_count != 16'hFFFF) overrun_count <= overrun_count + 16'd1;
      end
`endif
endmodule

// File: tb/tb_window_frame_scheduler.sv
// tb_window_frame_scheduler: directed bench for window_frame_scheduler with N=8, HOP=4.
`timescale 1ns/1ps
module tb_window_frame_scheduler;
   logic        clk = 1'b0;
   logic        reset, enable, in_valid, win_ready, win_frame_done;
   logic [15:0] in_sample;
   logic        in_ready, win_valid, frame_start, busy, seq_error;
   logic [15:0] win_sample, frame_count;
`ifdef WIN_SCHED_OVERRUN_EN
   logic [15:0] overrun_count;
   logic        overrun;
`endif
   int checks = 0, errs = 0;
   int src, starts, in_acc, acc_frame, done_cd;
   logic        prev_stall;
   logic [15:0] prev_sample;
   logic [15:0] got [$];
   always #5 clk = ~clk;
   window_frame_scheduler #(.W(16), .N(8), .HOP(4)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .in_sample(in_sample), .in_valid(in_valid), .in_ready(in_ready),
      .win_sample(win_sample), .win_valid(win_valid), .win_ready(win_ready),
      .win_frame_done(win_frame_done), .frame_start(frame_start), .busy(busy),
      .frame_count(frame_count), .seq_error(seq_error)
`ifdef WIN_SCHED_OVERRUN_EN
      , .overrun_count(overrun_count), .overrun(overrun)
`endif
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // One clock cycle, starting and ending at a falling edge. Done is auto-pulsed
   // 3 cycles after the 8th sample of each frame; xfd injects an extra pulse.
   task automatic step(input logic iv, input logic wr, input logic en, input logic xfd);
      win_frame_done = xfd || (done_cd == 1);
      if (done_cd > 0) done_cd--;
      in_valid = iv;
      win_ready = wr;
      enable = en;
      in_sample = 16'(src);
      #1;
      if (prev_stall) begin
         chk("hold_valid", 32'(win_valid), 1);
         chk("hold_sample", 32'(win_sample), 32'(prev_sample));
      end
      prev_stall = win_valid && !wr;
      prev_sample = win_sample;
      if (frame_start) starts++;
      if (iv && in_ready) begin
         src++;
         in_acc++;
      end
      if (win_valid && wr) begin
         got.push_back(win_sample);
         acc_frame++;
         if (acc_frame == 8) begin
            acc_frame = 0;
            done_cd = 3;
         end
      end
      @(negedge clk);
   endtask
   task automatic do_reset();
      reset = 1'b0;
      in_valid = 1'b0;
      win_ready = 1'b0;
      enable = 1'b0;
      win_frame_done = 1'b0;
      in_sample = '0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_win_valid", 32'(win_valid), 0);
      chk("rst_win_sample", 32'(win_sample), 0);
      chk("rst_frame_start", 32'(frame_start), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_frame_count", 32'(frame_count), 0);
      chk("rst_seq_error", 32'(seq_error), 0);
      reset = 1'b1;
      #1 chk("post_rst_in_ready", 32'(in_ready), 1);
      @(negedge clk);
      src = 0; starts = 0; in_acc = 0; acc_frame = 0; done_cd = 0; prev_stall = 1'b0;
      got.delete();
   endtask
   // Frame k (0-based) holds source samples 4k .. 4k+7.
   task automatic chk_frames(input string tag, input int nf);
      chk({tag, "_count"}, 32'(got.size()), 32'(nf * 8));
      for (int i = 0; i < got.size() && i < nf * 8; i++)
         chk(tag, 32'(got[i]), 32'(4 * (i / 8) + i % 8));
   endtask
   initial begin
      logic tog;
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      logic tog;
      @(negedge clk);
      // Full throughput, three frames
      do_reset();
      for (int i = 0; i < 300 && frame_count != 16'd3; i++) step(1, 1, 1, 0);
      chk("t1_frame_count", 32'(frame_count), 3);
      chk("t1_starts", 32'(starts), 3);
      chk("t1_seq_error", 32'(seq_error), 0);
      chk_frames("t1_sample", 3);
      // win_ready toggling every cycle
      do_reset();
      tog = 1'b1;
      for (int i = 0; i < 400 && frame_count != 16'd3; i++) begin
         step(1, tog, 1, 0);
         tog = ~tog;
      end
      chk("t2_frame_count", 32'(frame_count), 3);
      chk_frames("t2_sample", 3);
      // 20-cycle stall after the third accepted sample of frame 1
      do_reset();
      for (int i = 0; i < 100 && got.size() < 3; i++) step(1, 1, 1, 0);
      for (int i = 0; i < 20; i++) step(1, 0, 1, 0);
      chk("t3_stall_in_ready", 32'(in_ready), 0);
      chk("t3_stall_valid", 32'(win_valid), 1);
      chk("t3_stall_in_acc", 32'(in_acc), 11);
      for (int i = 0; i < 300 && frame_count != 16'd2; i++) step(1, 1, 1, 0);
      chk("t3_frame_count", 32'(frame_count), 2);
      chk_frames("t3_sample", 2);
      // enable low after the first launch
      do_reset();
      for (int i = 0; i < 100 && starts == 0; i++) step(1, 1, 1, 0);
      for (int i = 0; i < 40; i++) step(1, 1, 0, 0);
      chk("t4_starts_held", 32'(starts), 1);
      chk("t4_frame_count", 32'(frame_count), 1);
      chk("t4_in_ready", 32'(in_ready), 0);
      chk("t4_in_acc", 32'(in_acc), 12);
      chk("t4_busy", 32'(busy), 0);
      for (int i = 0; i < 100 && got.size() < 16; i++) step(1, 1, 1, 0);
      chk("t4_starts", 32'(starts), 2);
      chk_frames("t4_sample", 2);
      // stray done during STREAM, then reset in the middle of frame 3
      do_reset();
      for (int i = 0; i < 100 && got.size() < 2; i++) step(1, 1, 1, 0);
      step(1, 1, 1, 1);
      chk("t5_seq_error", 32'(seq_error), 1);
      for (int i = 0; i < 300 && frame_count != 16'd2; i++) step(1, 1, 1, 0);
      chk("t5_frame_count", 32'(frame_count), 2);
      chk_frames("t5_sample", 2);
      for (int i = 0; i < 100 && got.size() < 19; i++) step(1, 1, 1, 0);
      chk("t5_mid_valid", 32'(win_valid), 1);
      reset = 1'b0;
      #1 chk("t5_async_valid_drop", 32'(win_valid), 0);
      do_reset();
      for (int i = 0; i < 100 && got.size() < 8; i++) step(1, 1, 1, 0);
      chk_frames("t5_restart", 1);
`ifdef WIN_SCHED_OVERRUN_EN
      // overrun: buffer full and reader stalled for 10 cycles
      do_reset();
      for (int i = 0; i < 8; i++) step(1, 0, 1, 0);
      for (int i = 0; i < 10 && !busy; i++) step(0, 0, 1, 0);
      for (int i = 0; i < 10; i++) step(1, 0, 1, 0);
      chk("t6_overrun_count", 32'(overrun_count), 10);
      chk("t6_overrun", 32'(overrun), 1);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
      $finish;
   end
endmodule

// File: doc/window_frame_scheduler.md
Name: window_frame_scheduler

Overview:
- Sequences audio samples into the hanning window datapath as overlapping analysis frames of N samples with hop HOP.
- Stores incoming samples in an N-entry circular buffer.
- Replays each frame oldest-first to the window's sample_in/sample_in_valid/sample_in_ready port, then waits for the window's frame_done before scheduling the next frame.
- Sits between the audio sample source and hanning_window.

Parameters:
- W, 16, sample width in bits.
- N, 1024, frame length. Power of two; must equal the hanning_window N.
- HOP, 512, new samples per frame after the first. 1 <= HOP <= N.
- AW, $clog2(N), buffer address width (derived).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  permits launching a new frame; an in-progress frame always completes.
- in_sample  in  W  audio sample from the source.
- in_valid  in  1  in_sample valid.
- in_ready  out  1  scheduler accepts in_sample this cycle.
- win_sample  out  W  sample to hanning_window sample_in.
- win_valid  out  1  drives hanning_window sample_in_valid.
- win_ready  in  1  from hanning_window sample_in_ready.
- win_frame_done  in  1  frame_done pulse from hanning_window.
- frame_start  out  1  one-cycle pulse on frame launch.
- busy  out  1  high in STREAM or WAIT_DONE.
- frame_count  out  16  completed frames; wraps at 65535 -> 0.
- seq_error  out  1  sticky: win_frame_done seen outside WAIT_DONE.

Behaviour:
- Reset: all outputs 0, state FILL, wr_ptr = 0, base = 0, new_cnt = 0, rd_idx = 0, target = N, seq_error = 0. Buffer contents undefined.
- Input handshake:
  - A sample is written when in_valid && in_ready, at buffer[wr_ptr]. Then wr_ptr++ mod N and new_cnt++.
  - in_ready in FILL or WAIT_DONE = (new_cnt < target).
  - in_ready in STREAM = (new_cnt < rd_idx) && (new_cnt < HOP). Only slots already read are overwritten.
- FILL -> STREAM when new_cnt == target && enable. Same cycle:
  - frame_start = 1.
  - base = (first frame) ? 0 : base + HOP mod N.
  - new_cnt = 0, rd_idx = 0, target = HOP.
  - While enable = 0, the block stays in FILL and in_ready follows the FILL rule.
- STREAM:
  - Reads buffer[(base + rd_idx) mod N] in order.
  - rd_idx increments on each win_valid && win_ready.
  - Once win_valid is asserted, win_sample and win_valid hold stable until win_ready.
  - Full throughput: one sample per cycle while win_ready = 1.
  - Latency: first win_valid is at most 2 cycles after frame_start.
  - After the N-th accepted sample: win_valid = 0, go to WAIT_DONE.
- WAIT_DONE: on win_frame_done, frame_count++ and go to FILL (new_cnt is kept).
- win_frame_done in FILL or STREAM: ignored for sequencing; sets seq_error. Only reset clears seq_error.
- Simultaneous write and read in STREAM: allowed. The in_ready comparison uses registered rd_idx and new_cnt.
- HOP == N: no overlap; STREAM admits up to N writes behind the reader.
- Reset asserted mid-frame: immediate return to reset state. The partial frame is discarded; win_valid drops asynchronously.

Optional Feature:
- Macro: WIN_SCHED_OVERRUN_EN.
- Defined:
  - Adds output overrun_count [15:0], saturating at 0xFFFF. It increments every cycle with in_valid && !in_ready.
  - Adds output overrun (sticky, cleared by reset).
- Undefined: both ports absent; no counter logic.

Test Plan:
- N=8, HOP=4, enable=1, in_sample = 0,1,2,... each cycle, win_ready=1, win_frame_done 3 cycles after the last win sample:
  - frame 1 win_sample = 0..7, frame_start once.
  - frame 2 = 4..11, frame 3 = 8..15.
  - frame_count = 3 after the third done.
- Same stream with win_ready toggling 1/0 each cycle: identical sample sequences; win_sample stable during every win_ready=0 cycle.
- Continuous in_valid with win_ready=0 for 20 cycles mid-frame:
  - in_ready = 0 once new_cnt >= rd_idx; no buffer slot overwritten before it is read.
  - frame 2 still 4..11.
- enable=0 after frame 1: frame_start stays 0, in_ready drops after 4 new samples. Raising enable launches frame 2 = 4..11.
- win_frame_done pulsed during STREAM: seq_error = 1, sequencing unchanged. Later reset (low 2 cycles): all outputs 0, next frame starts from sample index 0.
- WIN_SCHED_OVERRUN_EN defined, in_valid held with win_ready=0 for 10 cycles after the buffer is full: overrun_count = 10, overrun = 1.
